// File: rtl/sram_arbiter_pkg.sv
// Shared types for the two-port round-robin SRAM arbiter: FSM states,
// requester ids and the round-robin winner selection.
package sram_arbiter_pkg;

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  typedef logic [0:0] req_id_t;

  localparam req_id_t REQ_R0 = 1'b0;
  localparam req_id_t REQ_R1 = 1'b1;

  // On contention the requester that was not granted last wins.
  function automatic req_id_t rr_winner(input logic req0, input logic req1, input req_id_t last);
    req_id_t win;
    if (req0 && req1) begin
      win = (last == REQ_R1) ? REQ_R0 : REQ_R1;
    end else if (req1) begin
      win = REQ_R1;
    end else begin
      win = REQ_R0;
    end
    return win;
  endfunction

endpackage

// File: rtl/sram_arbiter_sram.sv
// Single-port synchronous storage array with a registered read port;
// read data only changes on an enabled read.
module sram_arbiter_sram #(
  parameter  int DATA_WIDTH = 32,
  parameter  int N_ENTRIES  = 1024,
  localparam int AW         = $clog2(N_ENTRIES)
) (
  input  logic                  clk_i,
  input  logic                  en_i,
  input  logic                  we_i,
  input  logic [AW-1:0]         addr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [N_ENTRIES];
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [DATA_WIDTH-1:0] rdata_d;

  always_comb begin
    if (en_i && !we_i) begin
      rdata_d = mem_q[addr_i];
    end else begin
      rdata_d = rdata_q;
    end
  end

  // Storage is intentionally not reset so it maps onto block RAM.
  always_ff @(posedge clk_i) begin
    if (en_i && we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
    rdata_q <= rdata_d;
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/sram_arbiter.sv
// Round-robin arbiter sharing one single-port SRAM between r0 and r1.
// Define SRAM_ARBITER_INIT_EN to add a post-reset sweep that zeroes every entry.
module sram_arbiter
  import sram_arbiter_pkg::*;
#(
  parameter  int DATA_WIDTH = 32,
  parameter  int N_ENTRIES  = 1024,
  localparam int AW         = $clog2(N_ENTRIES)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  r0_req_i,
  input  logic                  r0_we_i,
  input  logic [AW-1:0]         r0_addr_i,
  input  logic [DATA_WIDTH-1:0] r0_data_i,
  input  logic                  r1_req_i,
  input  logic                  r1_we_i,
  input  logic [AW-1:0]         r1_addr_i,
  input  logic [DATA_WIDTH-1:0] r1_data_i,
  output logic                  r0_gnt_o,
  output logic                  r1_gnt_o,
  output logic                  r0_rvalid_o,
  output logic                  r1_rvalid_o,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic                  init_busy_o
);

  logic                  in_init;
  logic [AW-1:0]         init_addr;
  req_id_t               winner;
  logic                  gnt0, gnt1;
  req_id_t               ptr_q, ptr_d;
  logic                  rvalid0_q, rvalid0_d;
  logic                  rvalid1_q, rvalid1_d;
  logic                  sram_en, sram_we;
  logic [AW-1:0]         sram_addr;
  logic [DATA_WIDTH-1:0] sram_wdata;

`ifdef SRAM_ARBITER_INIT_EN
  state_e        state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_INIT: begin
        cnt_d = cnt_q + {{(AW-1){1'b0}}, 1'b1};
        if (cnt_q == AW'(N_ENTRIES - 1)) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_INIT;
        end
      end
      ST_RUN:  state_d = ST_RUN;
      default: state_d = ST_INIT;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign in_init   = (state_q == ST_INIT);
  assign init_addr = cnt_q;
`else
  assign in_init   = 1'b0;
  assign init_addr = '0;
`endif

  // Grants are combinational so a lone requester is served in the same cycle.
  always_comb begin
    winner = rr_winner(r0_req_i, r1_req_i, ptr_q);
    gnt0   = 1'b0;
    gnt1   = 1'b0;
    ptr_d  = ptr_q;
    if (!in_init && (r0_req_i || r1_req_i)) begin
      gnt0  = (winner == REQ_R0);
      gnt1  = (winner == REQ_R1);
      ptr_d = winner;
    end else begin
      ptr_d = ptr_q;
    end
  end

  always_comb begin
    sram_en    = 1'b0;
    sram_we    = 1'b0;
    sram_addr  = '0;
    sram_wdata = '0;
    if (in_init) begin
      sram_en    = 1'b1;
      sram_we    = 1'b1;
      sram_addr  = init_addr;
      sram_wdata = '0;
    end else if (gnt1) begin
      sram_en    = 1'b1;
      sram_we    = r1_we_i;
      sram_addr  = r1_addr_i;
      sram_wdata = r1_data_i;
    end else if (gnt0) begin
      sram_en    = 1'b1;
      sram_we    = r0_we_i;
      sram_addr  = r0_addr_i;
      sram_wdata = r0_data_i;
    end else begin
      sram_en    = 1'b0;
    end
  end

  assign rvalid0_d = gnt0 & ~r0_we_i;
  assign rvalid1_d = gnt1 & ~r1_we_i;

  // Pointer resets to r1 so r0 wins the first contention.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q     <= REQ_R1;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
    end else begin
      ptr_q     <= ptr_d;
      rvalid0_q <= rvalid0_d;
      rvalid1_q <= rvalid1_d;
    end
  end

  sram_arbiter_sram #(
    .DATA_WIDTH (DATA_WIDTH),
    .N_ENTRIES  (N_ENTRIES)
  ) u_sram (
    .clk_i   (clk_i),
    .en_i    (sram_en),
    .we_i    (sram_we),
    .addr_i  (sram_addr),
    .wdata_i (sram_wdata),
    .rdata_o (rdata_o)
  );

  assign r0_gnt_o    = gnt0;
  assign r1_gnt_o    = gnt1;
  assign r0_rvalid_o = rvalid0_q;
  assign r1_rvalid_o = rvalid1_q;
  assign init_busy_o = in_init;

endmodule

// File: tb/tb_sram_arbiter.sv
// Randomized self-checking bench for sram_arbiter against a transaction-level
// model (pending requests, last-granted id, array memory).
module tb_sram_arbiter;

  localparam int DW = 32;
  localparam int N  = 16;
  localparam int AW = 4;
`ifdef SRAM_ARBITER_INIT_EN
  localparam bit INIT_EN = 1'b1;
`else
  localparam bit INIT_EN = 1'b0;
`endif

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic          r0_req_i, r0_we_i, r1_req_i, r1_we_i;
  logic [AW-1:0] r0_addr_i, r1_addr_i;
  logic [DW-1:0] r0_data_i, r1_data_i;
  logic          r0_gnt_o, r1_gnt_o, r0_rvalid_o, r1_rvalid_o, init_busy_o;
  logic [DW-1:0] rdata_o;

  sram_arbiter #(.DATA_WIDTH(DW), .N_ENTRIES(N)) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .r0_req_i    (r0_req_i),
    .r0_we_i     (r0_we_i),
    .r0_addr_i   (r0_addr_i),
    .r0_data_i   (r0_data_i),
    .r1_req_i    (r1_req_i),
    .r1_we_i     (r1_we_i),
    .r1_addr_i   (r1_addr_i),
    .r1_data_i   (r1_data_i),
    .r0_gnt_o    (r0_gnt_o),
    .r1_gnt_o    (r1_gnt_o),
    .r0_rvalid_o (r0_rvalid_o),
    .r1_rvalid_o (r1_rvalid_o),
    .rdata_o     (rdata_o),
    .init_busy_o (init_busy_o)
  );

  always #5 clk_i = ~clk_i;

  int total = 0;
  int bad   = 0;

  // Reference model state
  bit            pv [2];
  bit            pwe [2];
  logic [AW-1:0] paddr [2];
  logic [DW-1:0] pdata [2];
  int            last_gnt;
  int            k;
  logic [DW-1:0] mem [N];
  bit            known [N];
  bit            exp_rv [2];
  logic [DW-1:0] exp_rd;
  bit            exp_rd_known;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic drive();
    r0_req_i  = pv[0];
    r0_we_i   = pwe[0];
    r0_addr_i = paddr[0];
    r0_data_i = pdata[0];
    r1_req_i  = pv[1];
    r1_we_i   = pwe[1];
    r1_addr_i = paddr[1];
    r1_data_i = pdata[1];
  endtask

  task automatic req(input int i, input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    pv[i]    = 1'b1;
    pwe[i]   = we;
    paddr[i] = a;
    pdata[i] = d;
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    pv[0]  = 1'b0;
    pv[1]  = 1'b0;
    drive();
    #1;
    check_val("rst_rvalid0", r0_rvalid_o, 1'b0);
    check_val("rst_rvalid1", r1_rvalid_o, 1'b0);
    check_val("rst_gnt0", r0_gnt_o, 1'b0);
    check_val("rst_gnt1", r1_gnt_o, 1'b0);
    check_val("rst_busy", init_busy_o, INIT_EN);
    repeat (2) @(posedge clk_i);
    #1 rst_ni = 1'b1;
    k            = 0;
    last_gnt     = 1;
    exp_rv[0]    = 1'b0;
    exp_rv[1]    = 1'b0;
    exp_rd_known = 1'b0;
  endtask

  // One clock: check outputs before the edge, then apply the model's view of that edge.
  task automatic cycle();
    bit busy;
    int w;
    drive();
    @(negedge clk_i);
    check_val("rvalid0", r0_rvalid_o, exp_rv[0]);
    check_val("rvalid1", r1_rvalid_o, exp_rv[1]);
    if ((exp_rv[0] || exp_rv[1]) && exp_rd_known) check_val("rdata", rdata_o, exp_rd);
    busy = INIT_EN && (k < N);
    check_val("init_busy", init_busy_o, busy);
    w = -1;
    if (!busy) begin
      if (pv[0] && pv[1]) w = 1 - last_gnt;
      else if (pv[0])     w = 0;
      else if (pv[1])     w = 1;
    end
    check_val("gnt0", r0_gnt_o, w == 0);
    check_val("gnt1", r1_gnt_o, w == 1);
    @(posedge clk_i);
    #1;
    exp_rv[0] = 1'b0;
    exp_rv[1] = 1'b0;
    if (busy) begin
      mem[k]   = '0;
      known[k] = 1'b1;
    end
    if (w >= 0) begin
      if (pwe[w]) begin
        mem[paddr[w]]   = pdata[w];
        known[paddr[w]] = 1'b1;
      end else begin
        exp_rv[w]    = 1'b1;
        exp_rd       = mem[paddr[w]];
        exp_rd_known = known[paddr[w]];
      end
      last_gnt = w;
      pv[w]    = 1'b0;
    end
    k++;
  endtask

  initial begin
    rst_ni = 1'b0;
    for (int i = 0; i < 2; i++) begin
      pv[i] = 1'b0; pwe[i] = 1'b0; paddr[i] = '0; pdata[i] = '0;
    end
    for (int i = 0; i < N; i++) known[i] = 1'b0;
    do_reset();

    // Both requesting from release; interrupt the sweep at count 7.
    req(0, 1'b0, AW'(3), '0);
    req(1, 1'b0, AW'(9), '0);
    repeat (7) cycle();
    do_reset();
    req(0, 1'b0, AW'(3), '0);
    req(1, 1'b0, AW'(9), '0);
    repeat (N + 3) cycle();

    for (int i = 0; i < N; i++) begin
      req(0, 1'b0, AW'(i), '0);
      cycle();
    end
    cycle();

    for (int i = 0; i < N; i++) begin
      req(1, 1'b1, AW'(i), $urandom);
      cycle();
    end

    // Write then immediate read-back on r0
    req(0, 1'b1, AW'(5), 32'hDEAD_BEEF);
    cycle();
    req(0, 1'b0, AW'(5), '0);
    cycle();
    cycle();

    // Continuous contention
    for (int c = 0; c < 4; c++) begin
      if (!pv[0]) req(0, 1'b0, AW'($urandom_range(0, N - 1)), '0);
      if (!pv[1]) req(1, 1'b0, AW'($urandom_range(0, N - 1)), '0);
      cycle();
    end
    repeat (2) cycle();

    // Simultaneous arrival: loser holds its request until granted
    req(0, 1'b0, AW'(7), '0);
    req(1, 1'b0, AW'(5), '0);
    repeat (3) cycle();

    // Reset right after a read grant drops its rvalid
    req(0, 1'b0, AW'(2), '0);
    cycle();
    do_reset();
    repeat (N + 1) cycle();

    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < 2; i++) begin
        if (!pv[i] && ($urandom_range(0, 3) != 0))
          req(i, 1'($urandom_range(0, 1)), AW'($urandom_range(0, N - 1)), $urandom);
      end
      cycle();
    end
    repeat (3) cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sram_arbiter.md
# sram_arbiter

Shares one single-port cache storage SRAM between two requesters (r0, r1) with round-robin arbitration and a valid/grant handshake. It returns registered read data one cycle after grant. An optional post-reset sequencer clears every entry before the first access. It sits between the cache control logic and the BRAM storage array it instantiates.

## Interface
- DATA_WIDTH, 32, word width of storage and data ports
- N_ENTRIES, 1024, number of words; AW = $clog2(N_ENTRIES)
- clk_i  in  1  single clock, all state on rising edge
- rst_ni  in  1  asynchronous, active-low reset
- r0_req_i / r1_req_i  in  1  request valid, held until granted
- r0_we_i / r1_we_i  in  1  1 = write, 0 = read
- r0_addr_i / r1_addr_i  in  AW  word address
- r0_data_i / r1_data_i  in  DATA_WIDTH  write data
- r0_gnt_o / r1_gnt_o  out  1  access issued to SRAM at this edge (combinational)
- r0_rvalid_o / r1_rvalid_o  out  1  read data valid, one cycle after read grant
- rdata_o  out  DATA_WIDTH  shared read data, qualified only by rvalid
- init_busy_o  out  1  clear sequence in progress, no grants

## Operation
- States: INIT (clear sweep), RUN. Reset enters INIT when the macro is defined, otherwise RUN.
- INIT behaviour:
  - A counter walks 0..N_ENTRIES-1, writing 0 to each entry, one entry per cycle.
  - Both gnt outputs are 0 and init_busy_o is 1.
  - After writing N_ENTRIES-1, go to RUN.
- RUN arbitration:
  - A single requester is granted immediately.
  - If both request, the requester not granted last wins.
  - The pointer updates on every grant; its reset value makes r0 win the first contention.
- Exactly one grant per cycle, so r0 and r1 never collide on the SRAM.
- Granted requester drives en=1, we, addr, data to the SRAM. With no grant, en=0.
- Read grant: that requester's rvalid_o goes high the next cycle, with rdata_o = SRAM[addr].
- Write grant: no rvalid is produced.
- rdata_o holds its last value while SRAM en=0.
- Ungranted requests wait. The requester must keep req/we/addr/data stable until gnt.

## Timing
- gnt_o is combinational from req, state and pointer, with no request-to-grant delay in RUN.
- Read latency is 1 cycle: grant at edge N, rvalid_o and rdata_o valid after edge N until edge N+1.
- Throughput: one access per cycle total. Two contending streams alternate r0, r1, r0, …
- Write at edge N followed by a read of the same address at edge N+1 returns the new data.
- Reset values:
  - gnt_o = 0 and rvalid_o = 0.
  - init_busy_o = 1 with INIT_EN, 0 without.
  - Pointer = r1 (last granted), so r0 wins first.
  - Init counter = 0.
  - rdata_o is not reset; it is don't-care until the first rvalid.
- Reset asserted mid-INIT restarts the sweep at address 0. Reset asserted mid-read drops the pending rvalid.
- INIT duration is exactly N_ENTRIES cycles after reset deassertion. init_busy_o falls on the edge that writes the last entry.

## Configuration
- SRAM_ARBITER_INIT_EN defined:
  - INIT state, counter and clear sweep are compiled in.
  - All entries read 0 after init.
- Not defined:
  - No INIT state and no counter.
  - init_busy_o is tied 0.
  - Grants are available from the first cycle after reset; storage contents are undefined.

## Structure
- Package sram_arbiter_pkg:
  - state enum {ST_INIT, ST_RUN}
  - requester id constants REQ_R0 = 0, REQ_R1 = 1
- The arbitration pointer uses the requester id type.
- Sub-module: instantiate the existing sram block (DATA_WIDTH, N_ENTRIES passed through) as the storage. The arbiter only drives its en, we, addr and data.

## Test plan
- INIT_EN, N_ENTRIES=16: release reset
  - init_busy_o stays 1 for 16 cycles, with no gnt despite both req high.
  - Reads of addresses 0..15 then return 0.
- Single requester: r0 writes 0xDEADBEEF to address 5, then reads 5 the next cycle
  - gnt each cycle.
  - r0_rvalid_o is 1 one cycle after the read grant, with rdata_o = 0xDEADBEEF.
  - r1_rvalid_o stays 0.
- Contention: r0 and r1 both read continuously for 4 cycles
  - Grants go r0, r1, r0, r1.
  - Each rvalid follows its grant by 1 cycle with correct data.
- Hold check: r1 requests while r0 holds priority
  - r1 waits one cycle with its inputs stable, is granted the next cycle, and its data appears a cycle later.
- Reset mid-INIT: assert rst_ni low at init count 7, then release
  - The sweep restarts at 0 and init_busy_o lasts the full N_ENTRIES cycles.
- Without the macro: a read issued in the first cycle after reset is granted immediately, and init_busy_o is 0 throughout.
